// File: rtl/regfile_2r1w_sb_pkg.sv
// Shared constants for the 2-read/1-write register file:
// instruction field positions, reset content and named register indices.
package regfile_2r1w_sb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int RS_LSB_DEF = 21;
    localparam int RT_LSB_DEF = 16;
    localparam logic [31:0] RESET_VAL_DEF = 32'hAAAAAAAA;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_T0 = 5'd8;
    localparam logic [4:0] REG_T1 = 5'd9;
    localparam logic [4:0] REG_T2 = 5'd10;
    localparam logic [4:0] REG_T3 = 5'd11;
    localparam logic [4:0] REG_T4 = 5'd12;
    localparam logic [4:0] REG_T5 = 5'd13;
    localparam logic [4:0] REG_T6 = 5'd14;
    localparam logic [4:0] REG_T7 = 5'd15;
    localparam logic [4:0] REG_S0 = 5'd16;
    localparam logic [4:0] REG_S1 = 5'd17;
    localparam logic [4:0] REG_S2 = 5'd18;
    localparam logic [4:0] REG_S3 = 5'd19;
    localparam logic [4:0] REG_S4 = 5'd20;
    localparam logic [4:0] REG_S5 = 5'd21;
    localparam logic [4:0] REG_S6 = 5'd22;
    localparam logic [4:0] REG_S7 = 5'd23;
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register awaiting a load result,
// plus the hazard terms for the two read indices.
module regfile_scoreboard
    import regfile_2r1w_sb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = 32,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic                pend_set,
    input  logic [ADDR_W-1:0]   pend_addr,
    input  logic [ADDR_W-1:0]   rs,
    input  logic [ADDR_W-1:0]   rt,
    output logic                hz_a,
    output logic                hz_b,
    output logic [NUM_REGS-1:0] pend_vec
);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] set_v;
    logic [NUM_REGS-1:0] clr_v;
    logic                byp_a;
    logic                byp_b;

    // Index 0 is never decoded, so pend[0] stays at its reset value of 0.
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            set_v[i] = pend_set && (pend_addr == ADDR_W'(i));
            clr_v[i] = we && (waddr == ADDR_W'(i));
        end
    end

    assign byp_a = BYPASS && we && (waddr == rs);
    assign byp_b = BYPASS && we && (waddr == rt);

    always_comb begin
        hz_a = 1'b0;
        hz_b = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs == ADDR_W'(i)) hz_a = pend[i];
            if (rt == ADDR_W'(i)) hz_b = pend[i];
        end
        hz_a = hz_a & ~byp_a;
        hz_b = hz_b & ~byp_b;
    end

    // Set is applied after clear so a new outstanding load wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr_v) | set_v;
        end
    end

    assign pend_vec = pend;

endmodule

// File: rtl/regfile_2r1w_sb.sv
// Register file with two registered read ports, one write port,
// write-first bypass, hardwired zero register and load scoreboard stall.
module regfile_2r1w_sb
    import regfile_2r1w_sb_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          NUM_REGS  = 32,
    parameter logic [31:0] RESET_VAL = RESET_VAL_DEF,
    parameter bit          BYPASS    = 1'b1,
    parameter int          RS_LSB    = RS_LSB_DEF,
    parameter int          RT_LSB    = RT_LSB_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                rd_req,
    output logic                stall,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   data_a,
    output logic [DATA_W-1:0]   data_b,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                pend_set,
    input  logic [ADDR_W-1:0]   pend_addr,
    output logic [NUM_REGS-1:0] pend_vec
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic              hz_a;
    logic              hz_b;
    logic              accept;
    logic              unused_instr;

    assign rs = instr[RS_LSB +: ADDR_W];
    assign rt = instr[RT_LSB +: ADDR_W];
    assign unused_instr = ^instr;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .rs        (rs),
        .rt        (rt),
        .hz_a      (hz_a),
        .hz_b      (hz_b),
        .pend_vec  (pend_vec)
    );

    assign stall  = rd_req & (hz_a | hz_b);
    assign accept = rd_req & ~stall;

    // Out-of-range and zero indices never match the loop, so they read 0.
    always_comb begin
        val_a = '0;
        val_b = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs == ADDR_W'(i)) val_a = regs[i];
            if (rt == ADDR_W'(i)) val_b = regs[i];
        end
        if (BYPASS && we && (waddr == rs) && (rs != '0)
            && (int'(rs) < NUM_REGS)) begin
            val_a = wdata;
        end
        if (BYPASS && we && (waddr == rt) && (rt != '0)
            && (int'(rt) < NUM_REGS)) begin
            val_b = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs[0] <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(RESET_VAL);
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (we && (waddr == ADDR_W'(i))) regs[i] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a   <= '0;
            data_b   <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= accept;
            if (accept) begin
                data_a <= val_a;
                data_b <= val_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Scoreboard-driven bench for regfile_2r1w_sb (BYPASS=1, 32x32):
// directed cases, random traffic and an asynchronous reset mid-stall.
module tb_regfile_2r1w_sb;
    import regfile_2r1w_sb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        rd_req = 1'b0;
    logic        stall;
    logic        rd_valid;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        pend_set = 1'b0;
    logic [4:0]  pend_addr = '0;
    logic [31:0] pend_vec;

    int errors = 0;
    int checks = 0;

    logic [31:0] mregs [32];
    logic [31:0] mpend;
    logic [63:0] expq [$];

    always #5 clk = ~clk;

    regfile_2r1w_sb #(.BYPASS(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .rd_req    (rd_req),
        .stall     (stall),
        .rd_valid  (rd_valid),
        .data_a    (data_a),
        .data_b    (data_b),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .pend_vec  (pend_vec)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] s,
                                       input logic [4:0] t);
        return {6'b0, s, t, 16'h0};
    endfunction

    task automatic model_reset();
        mregs[0] = '0;
        for (int i = 1; i < 32; i++) mregs[i] = 32'hAAAAAAAA;
        mpend = '0;
        expq.delete();
    endtask

    function automatic logic [31:0] mval(input logic [4:0] i,
                                         input logic w,
                                         input logic [4:0] wa,
                                         input logic [31:0] wd);
        if (i == 0) return '0;
        if (w && wa == i) return wd;
        return mregs[i];
    endfunction

    function automatic logic mhz(input logic [4:0] i, input logic w,
                                 input logic [4:0] wa);
        return mpend[i] && !(w && wa == i);
    endfunction

    // Entered and left at posedge+1.
    task automatic cycle(input logic rq, input logic [31:0] ins,
                         input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ps,
                         input logic [4:0] pa);
        logic [4:0]  s;
        logic [4:0]  t;
        logic        exp_st;
        logic        acc;
        logic [63:0] e;
        rd_req = rq;
        instr = ins;
        we = w;
        waddr = wa;
        wdata = wd;
        pend_set = ps;
        pend_addr = pa;
        s = ins[25:21];
        t = ins[20:16];
        exp_st = rq && (mhz(s, w, wa) || mhz(t, w, wa));
        acc = rq && !exp_st;
        #3;
        check("stall", 64'(stall), 64'(exp_st));
        if (acc) expq.push_back({mval(s, w, wa, wd), mval(t, w, wa, wd)});
        @(posedge clk);
        if (w && wa != 0) mregs[wa] = wd;
        if (w) mpend[wa] = 1'b0;
        if (ps && pa != 0) mpend[pa] = 1'b1;
        #1;
        check("rd_valid", 64'(rd_valid), 64'(acc));
        check("pend_vec", 64'(pend_vec), 64'(mpend));
        if (rd_valid) begin
            check("q_nonempty", 64'(expq.size() != 0), 64'(1));
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("data_a", 64'(data_a), 64'(e[63:32]));
                check("data_b", 64'(data_b), 64'(e[31:0]));
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        model_reset();
        rd_req = 1'b1;
        instr = mk(REG_S1, REG_S1);
        #12;
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_data_a", 64'(data_a), 64'(0));
        check("rst_data_b", 64'(data_b), 64'(0));
        check("rst_pend_vec", 64'(pend_vec), 64'(0));
        check("rst_stall", 64'(stall), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cycle(1'b1, mk(REG_T0, REG_S0), 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b1, mk(REG_ZERO, REG_T0), 1'b0, '0, '0, 1'b0, '0);

        cycle(1'b1, mk(REG_T1, REG_ZERO), 1'b1, REG_T1,
              32'h12345678, 1'b0, '0);
        cycle(1'b1, mk(REG_T1, REG_T1), 1'b0, '0, '0, 1'b0, '0);

        cycle(1'b0, '0, 1'b1, REG_ZERO, 32'hFFFFFFFF, 1'b1, REG_ZERO);
        cycle(1'b1, mk(REG_ZERO, REG_ZERO), 1'b0, '0, '0, 1'b0, '0);

        cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, REG_S1);
        cycle(1'b1, mk(REG_T0, REG_S1), 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b1, mk(REG_T0, REG_S1), 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b1, mk(REG_T0, REG_S1), 1'b1, REG_S1,
              32'h5A5A5A5A, 1'b0, '0);
        idle();

        cycle(1'b0, '0, 1'b1, REG_T4, 32'hC0FFEE00, 1'b1, REG_T4);
        cycle(1'b1, mk(REG_T4, REG_ZERO), 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b0, '0, 1'b1, REG_T4, 32'hC0FFEE00, 1'b0, '0);
        cycle(1'b1, mk(REG_T4, REG_T4), 1'b0, '0, '0, 1'b0, '0);
        idle();

        for (int n = 0; n < 60; n++) begin
            cycle($urandom_range(0, 3) != 0,
                  mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
                  $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom(),
                  $urandom_range(0, 3) == 0,
                  5'($urandom_range(0, 7)));
        end
        idle();
        idle();

        cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, REG_S4);
        cycle(1'b1, mk(REG_T3, REG_S0), 1'b0, '0, '0, 1'b0, '0);
        rd_req = 1'b1;
        instr = mk(REG_S4, REG_S4);
        we = 1'b0;
        pend_set = 1'b0;
        #1;
        check("pre_rst_stall", 64'(stall), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_pend_vec", 64'(pend_vec), 64'(0));
        check("mid_rst_rd_valid", 64'(rd_valid), 64'(0));
        check("mid_rst_data_a", 64'(data_a), 64'(0));
        check("mid_rst_data_b", 64'(data_b), 64'(0));
        check("mid_rst_stall", 64'(stall), 64'(0));
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, mk(REG_T4, REG_S4), 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b1, mk(REG_T1, REG_RA), 1'b0, '0, '0, 1'b0, '0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Parametrised register file: two read ports decoded from the instruction rs/rt fields, one write port.
- Registered read outputs, write-first bypass, hardwired zero register, and a per-register pending-write scoreboard that stalls reads of registers awaiting a load result.
- Sits between instruction fetch/decode and the ALU operand latches. Supplies data_a/data_b one cycle after a read request is accepted.

Parameters:
- DATA_W, 32: register and port data width.
- ADDR_W, 5: register index width; also the width of the rs/rt fields.
- NUM_REGS, 32: implemented registers, indices 0..NUM_REGS-1, with NUM_REGS <= 2**ADDR_W.
- RESET_VAL, 32'hAAAAAAAA: reset content of registers 1..NUM_REGS-1, truncated to DATA_W.
- BYPASS, 1: 1 = a same-cycle write is forwarded to a read of the same index; 0 = the read returns the pre-write value.
- RS_LSB, 21: LSB of the rs field in instr.
- RT_LSB, 16: LSB of the rt field in instr.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction word; rs = instr[RS_LSB+ADDR_W-1:RS_LSB], rt = instr[RT_LSB+ADDR_W-1:RT_LSB].
- rd_req  in  1  read request for the current instr.
- stall  out  1  combinational; request not accepted this cycle.
- rd_valid  out  1  data_a/data_b updated by an accepted request.
- data_a  out  DATA_W  value of register rs.
- data_b  out  DATA_W  value of register rt.
- we  in  1  write enable.
- waddr  in  ADDR_W  write index.
- wdata  in  DATA_W  write data.
- pend_set  in  1  mark pend_addr as awaiting a write.
- pend_addr  in  ADDR_W  index to mark pending.
- pend_vec  out  NUM_REGS  current scoreboard bits, for debug.

Behaviour:
Reset (asynchronous assert, synchronous release):
- reg[0]=0; reg[1..NUM_REGS-1]=RESET_VAL.
- pend_vec=0, data_a=0, data_b=0, rd_valid=0.
- stall=0 for as long as rst_n=0.
- Reset mid-operation discards pending bits and any in-flight read.

Write:
- At posedge, if we=1 and 0<waddr<NUM_REGS: reg[waddr]<=wdata.
- waddr=0 or waddr>=NUM_REGS: no register changes.

Read:
- accept = rd_req & ~stall.
- On an accepted request at posedge: data_a<=val(rs), data_b<=val(rt), rd_valid<=1. Latency is 1 cycle.
- When accept=0: data_a/data_b hold and rd_valid<=0.
- val(i) = 0 if i=0 or i>=NUM_REGS.
- val(i) = wdata if BYPASS=1, we=1 and waddr=i (write-first).
- Otherwise val(i) = reg[i].

Scoreboard:
- At posedge, pend_set=1 with 0<pend_addr<NUM_REGS sets pend[pend_addr].
- we=1 with a valid waddr clears pend[waddr].
- Set and clear on the same index in the same cycle: set wins (a new load is outstanding).
- pend[0] is always 0.

Stall:
- stall = rd_req & (hz(rs) | hz(rt)).
- hz(i) = pend[i] & ~(BYPASS & we & waddr==i).
- With BYPASS=0, a pending register stalls until the cycle after its clearing write.

Other rules:
- rs=rt is legal; both outputs carry the same value.
- No arithmetic is performed. All width truncation is to DATA_W.

Decomposition:
- Shared package: ADDR_W default, RS_LSB/RT_LSB, and register index constants.
  - REG_ZERO=0, REG_T0..REG_T7=8..15, REG_S0..REG_S7=16..23, REG_RA=31.
  - Also the RESET_VAL default.
- One sub-module: regfile_scoreboard. It holds the pend bits and computes set/clear priority and hz() for both read indices.
- The storage array and the bypass muxes stay in the top module.

Test Plan:
1. Reset, then read rs=8, rt=16 -> next cycle rd_valid=1, data_a=data_b=32'hAAAAAAAA. Read rs=0 -> data_a=0.
2. Write waddr=9, wdata=32'h12345678 while reading rs=9 in the same cycle:
   - BYPASS=1 -> data_a=32'h12345678.
   - BYPASS=0 -> 32'hAAAAAAAA, then 32'h12345678 on the following read.
3. Write waddr=0, wdata=32'hFFFFFFFF, then read rs=0 -> data_a=0. pend_set with pend_addr=0 -> pend_vec stays 0.
4. pend_set on index 17, then rd_req with rt=17 -> stall=1 and rd_valid=0 on each cycle until we=1, waddr=17, wdata=32'h5A5A5A5A.
   - BYPASS=1 -> stall drops in the write cycle and data_b=32'h5A5A5A5A next cycle.
   - pend_vec[17] then reads 0.
5. pend_set and we both on index 12 in the same cycle -> pend_vec[12]=1 afterwards and reg[12]=wdata.
6. Assert rst_n=0 mid-stall with pend bits set and rd_valid=1 -> immediately pend_vec=0, rd_valid=0, data_a=data_b=0, stall=0. Registers return to RESET_VAL.
